// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if
//   Display-bus bundle for the 7-segment scan decoder.
//   master : drives the display pins (anodes, segments) and observes results.
//   slave  : the decoder; samples the pins and drives value/status.
//   anodes[3:0]   one-hot digit select (polarity set by the decoder parameters)
//   segments[6:0] bit0=a .. bit6=g
//   value[15:0]   committed nibbles, digit i at value[4i+3:4i]
//   digit_valid, blank [3:0]; illegal, update, locked single-bit status
interface seg7_scan_decoder_if;
   logic [3:0]  anodes;
   logic [6:0]  segments;
   logic [15:0] value;
   logic [3:0]  digit_valid;
   logic [3:0]  blank;
   logic        illegal;
   logic        update;
   logic        locked;

   modport master (
      output anodes, segments,
      input  value, digit_valid, blank, illegal, update, locked
   );

   modport slave (
      input  anodes, segments,
      output value, digit_valid, blank, illegal, update, locked
   );
endinterface

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//   Watches a multiplexed 4-digit 7-segment bus, waits for each digit to
//   settle, decodes the pattern back to a hex nibble and commits it once the
//   same pattern has been sampled MATCH_COUNT times in a row.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    seg7_scan_decoder_if.slave (anodes/segments in, status out)
module seg7_scan_decoder #(
   parameter bit          COMMON_ANODE     = 1'b0,
   parameter bit          ANODE_ACTIVE_LOW = 1'b1,
   parameter int unsigned SETTLE_CYCLES    = 4,
   parameter int unsigned MATCH_COUNT      = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   seg7_scan_decoder_if.slave  bus
);

   localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);
   localparam logic [3:0] MATCH  = 4'(MATCH_COUNT);

   logic [10:0] in_d, in_q;
   logic [3:0]  an_d_n, an_q_n;
   logic [6:0]  seg_q_n;
   logic [7:0]  cnt, cnt_nx;
   logic        hit, hit_nx;
   logic        load, oh_d;
   logic [1:0]  sel;

   logic [3:0]  cand_nib   [4];
   logic        cand_blank [4];
   logic [3:0]  mcnt       [4];

   logic [15:0] value;
   logic [3:0]  digit_valid, blank;
   logic        illegal, update;

   logic [3:0]  dec_nib;
   logic        dec_blank, dec_ill;
   logic [3:0]  mcnt_nx;
   logic        do_commit;

   assign in_d    = {bus.anodes, bus.segments};
   assign an_d_n  = ANODE_ACTIVE_LOW ? ~in_d[10:7] : in_d[10:7];
   assign an_q_n  = ANODE_ACTIVE_LOW ? ~in_q[10:7] : in_q[10:7];
   assign seg_q_n = COMMON_ANODE     ? ~in_q[6:0]  : in_q[6:0];

   // Settle counter is evaluated on the value about to enter in_q, so the
   // count after edge k equals the number of stable one-hot cycles so far.
   // hit marks the single cycle where the count first lands on SETTLE.
   always_comb begin
      load   = (in_d != in_q);
      oh_d   = $onehot(an_d_n);
      cnt_nx = '0;
      if (oh_d) begin
         if (load)                cnt_nx = 8'd1;
         else if (cnt >= SETTLE)  cnt_nx = SETTLE;
         else                     cnt_nx = cnt + 8'd1;
      end
      hit_nx = oh_d && (cnt_nx == SETTLE) && (load || (cnt != SETTLE));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_q <= '0;
         cnt  <= '0;
         hit  <= 1'b0;
      end else begin
         in_q <= in_d;
         cnt  <= cnt_nx;
         hit  <= hit_nx;
      end
   end

   always_comb begin
      sel = '0;
      for (int unsigned i = 0; i < 4; i++)
         if (an_q_n[i]) sel = 2'(i);
   end

   always_comb begin
      dec_nib   = '0;
      dec_blank = 1'b0;
      dec_ill   = 1'b0;
      unique case (seg_q_n)
         7'h3F: dec_nib = 4'h0;
         7'h06: dec_nib = 4'h1;
         7'h5B: dec_nib = 4'h2;
         7'h4F: dec_nib = 4'h3;
         7'h66: dec_nib = 4'h4;
         7'h6D: dec_nib = 4'h5;
         7'h7D: dec_nib = 4'h6;
         7'h07: dec_nib = 4'h7;
         7'h7F: dec_nib = 4'h8;
         7'h6F: dec_nib = 4'h9;
         7'h77: dec_nib = 4'hA;
         7'h7C: dec_nib = 4'hB;
         7'h39: dec_nib = 4'hC;
         7'h5E: dec_nib = 4'hD;
         7'h79: dec_nib = 4'hE;
         7'h71: dec_nib = 4'hF;
         7'h00: dec_blank = 1'b1;
         default: dec_ill = 1'b1;
      endcase
   end

   always_comb begin
      mcnt_nx = 4'd1;
      if ({dec_blank, dec_nib} == {cand_blank[sel], cand_nib[sel]})
         mcnt_nx = (mcnt[sel] >= MATCH) ? MATCH : mcnt[sel] + 4'd1;
      do_commit = hit && !dec_ill && (mcnt_nx == MATCH) &&
                  (!digit_valid[sel] ||
                   value[{sel, 2'b00} +: 4] != dec_nib ||
                   blank[sel] != dec_blank);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 4; i++) begin
            cand_nib[i]   <= '0;
            cand_blank[i] <= 1'b0;
            mcnt[i]       <= '0;
         end
         value       <= '0;
         digit_valid <= '0;
         blank       <= '0;
         illegal     <= 1'b0;
         update      <= 1'b0;
      end else begin
         illegal <= 1'b0;
         update  <= 1'b0;
         if (hit) begin
            if (dec_ill) begin
               illegal   <= 1'b1;
               mcnt[sel] <= '0;
            end else begin
               cand_nib[sel]   <= dec_nib;
               cand_blank[sel] <= dec_blank;
               mcnt[sel]       <= mcnt_nx;
               if (do_commit) begin
                  value[{sel, 2'b00} +: 4] <= dec_nib;
                  blank[sel]               <= dec_blank;
                  digit_valid[sel]         <= 1'b1;
                  update                   <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.value       = value;
   assign bus.digit_valid = digit_valid;
   assign bus.blank       = blank;
   assign bus.illegal     = illegal;
   assign bus.update      = update;
   assign bus.locked      = &digit_valid;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder
//   Drives dwells (digit select + pattern held for N cycles) and compares the
//   decoder outputs with a sample-level reference model after every dwell.
module tb_seg7_scan_decoder;

   localparam int SETTLE = 4;
   localparam int MATCH  = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seg7_scan_decoder_if bus ();

   seg7_scan_decoder #(
      .COMMON_ANODE     (1'b0),
      .ANODE_ACTIVE_LOW (1'b1),
      .SETTLE_CYCLES    (SETTLE),
      .MATCH_COUNT      (MATCH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   int checks = 0;
   int errors = 0;

   // reference model state, one entry per digit
   int m_val [4], m_blank [4], m_valid [4], m_cand [4], m_cnt [4];
   int exp_upd = 0, exp_ill = 0;
   int prev_in = -1;

   // pulse monitor
   int upd_seen = 0, ill_seen = 0, lock_err = 0;
   logic lk_prev = 1'b0;

   always @(negedge clk) begin
      if (bus.update)  upd_seen++;
      if (bus.illegal) ill_seen++;
      if (bus.locked && !lk_prev && !bus.update) lock_err++;
      if (bus.locked != &bus.digit_valid)        lock_err++;
      lk_prev = bus.locked;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] m_value();
      return 16'((m_val[3] << 12) | (m_val[2] << 8) | (m_val[1] << 4) | m_val[0]);
   endfunction

   function automatic logic [3:0] m_bits(input int which);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = (which == 0) ? m_valid[i][0] : m_blank[i][0];
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_val[i] = 0; m_blank[i] = 0; m_valid[i] = 0; m_cand[i] = 0; m_cnt[i] = 0;
      end
      prev_in = -1;
   endtask

   // One sample of pattern p on digit d, following the commit rules directly.
   task automatic model_sample(input int d, input logic [6:0] p);
      int nib, bl, c;
      nib = -1; bl = 0;
      if (p == 7'h00) begin nib = 0; bl = 1; end
      else for (int n = 0; n < 16; n++) if (tbl[n] == p) nib = n;
      if (nib < 0) begin
         exp_ill++;
         m_cnt[d] = 0;
         return;
      end
      c = bl * 16 + nib;
      if (c == m_cand[d]) m_cnt[d] = (m_cnt[d] + 1 > MATCH) ? MATCH : m_cnt[d] + 1;
      else begin m_cand[d] = c; m_cnt[d] = 1; end
      if (m_cnt[d] == MATCH && (m_valid[d] == 0 || m_val[d] != nib || m_blank[d] != bl)) begin
         m_val[d] = nib; m_blank[d] = bl; m_valid[d] = 1;
         exp_upd++;
      end
   endtask

   task automatic dwell(input logic [3:0] an, input logic [6:0] sg, input int unsigned len);
      int cur, d;
      bus.anodes   = an;
      bus.segments = sg;
      repeat (len) @(negedge clk);
      #1;
      cur = int'({an, sg});
      if (cur != prev_in && $countones(~an) == 1 && len >= SETTLE) begin
         d = 0;
         for (int i = 0; i < 4; i++) if (!an[i]) d = i;
         model_sample(d, sg);
      end
      prev_in = cur;
      chk("value",       32'(bus.value),       32'(m_value()));
      chk("digit_valid", 32'(bus.digit_valid), 32'(m_bits(0)));
      chk("blank",       32'(bus.blank),       32'(m_bits(1)));
      chk("update_cnt",  32'(upd_seen),        32'(exp_upd));
      chk("illegal_cnt", 32'(ill_seen),        32'(exp_ill));
   endtask

   task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                       input logic [6:0] p2, input logic [6:0] p3);
      dwell(4'b1110, p0, 8);
      dwell(4'b1101, p1, 8);
      dwell(4'b1011, p2, 8);
      dwell(4'b0111, p3, 8);
   endtask

   initial begin
      int disp [4];
      logic [3:0] an;
      logic [6:0] sg;
      int unsigned len;
      int mode, ok;

      model_reset();
      bus.anodes   = 4'b1111;
      bus.segments = 7'h00;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_value",   32'(bus.value),       32'h0);
      chk("rst_valid",   32'(bus.digit_valid), 32'h0);
      chk("rst_blank",   32'(bus.blank),       32'h0);
      chk("rst_illegal", 32'(bus.illegal),     32'h0);
      chk("rst_update",  32'(bus.update),      32'h0);
      chk("rst_locked",  32'(bus.locked),      32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // basic lock-up: two full scans
      scan(7'h4F, 7'h66, 7'h6D, 7'h7D);
      chk("one_scan_no_commit", 32'(bus.digit_valid), 32'h0);
      scan(7'h4F, 7'h66, 7'h6D, 7'h7D);
      chk("lock_value",  32'(bus.value),  32'h6543);
      chk("lock_valid",  32'(bus.digit_valid), 32'hF);
      chk("lock_updates", 32'(upd_seen), 32'd4);
      chk("locked",      32'(bus.locked), 32'h1);

      // short dwells and multi-anode selects never sample
      for (int k = 0; k < 4; k++) begin
         dwell(4'b1110, 7'h3F, 3);
         dwell(4'b1101, 7'h06, 3);
      end
      dwell(4'b1100, 7'h06, 10);
      dwell(4'b0000, 7'h5B, 10);
      dwell(4'b1111, 7'h55, 10);
      chk("glitch_value", 32'(bus.value), 32'h6543);

      // digit 1 alternating: no commit until a pattern repeats
      scan(7'h4F, 7'h4F, 7'h6D, 7'h7D);
      scan(7'h4F, 7'h5B, 7'h6D, 7'h7D);
      scan(7'h4F, 7'h4F, 7'h6D, 7'h7D);
      scan(7'h4F, 7'h5B, 7'h6D, 7'h7D);
      chk("alt_hold", 32'(bus.value), 32'h6543);
      scan(7'h4F, 7'h5B, 7'h6D, 7'h7D);
      chk("alt_commit", 32'(bus.value), 32'h6523);

      // blank digit 2
      scan(7'h4F, 7'h5B, 7'h00, 7'h7D);
      scan(7'h4F, 7'h5B, 7'h00, 7'h7D);
      chk("blank_bits",  32'(bus.blank), 32'h4);
      chk("blank_value", 32'(bus.value), 32'h6023);

      // asynchronous reset in the middle of a dwell
      bus.anodes = 4'b1101; bus.segments = 7'h66;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_value",  32'(bus.value),       32'h0);
      chk("arst_valid",  32'(bus.digit_valid), 32'h0);
      chk("arst_blank",  32'(bus.blank),       32'h0);
      chk("arst_locked", 32'(bus.locked),      32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // illegal pattern on digit 0 after reset
      scan(7'h55, 7'h66, 7'h6D, 7'h7D);
      chk("post_rst_one_scan", 32'(bus.value), 32'h0);
      scan(7'h55, 7'h66, 7'h6D, 7'h7D);
      chk("illegal_valid", 32'(bus.digit_valid), 32'hE);
      chk("illegal_value", 32'(bus.value), 32'h6540);
      scan(7'h4F, 7'h66, 7'h6D, 7'h7D);
      scan(7'h4F, 7'h66, 7'h6D, 7'h7D);
      chk("relock_value", 32'(bus.value), 32'h6543);

      // randomized scanning with glitches, illegal patterns and content changes
      for (int i = 0; i < 4; i++) disp[i] = $urandom_range(0, 16);
      for (int k = 0; k < 200; k++) begin
         int d;
         d = k % 4;
         if ($urandom_range(0, 7) == 0) disp[d] = $urandom_range(0, 16);
         an  = ~(4'b0001 << d);
         sg  = (disp[d] == 16) ? 7'h00 : tbl[disp[d]];
         len = $urandom_range(5, 10);
         mode = $urandom_range(0, 9);
         if (mode == 0) len = $urandom_range(1, 3);
         else if (mode == 1) begin
            an = 4'($urandom);
            while ($countones(~an) == 1) an = 4'($urandom);
         end else if (mode == 2) begin
            ok = 0;
            while (!ok) begin
               sg = 7'($urandom);
               ok = (sg != 7'h00);
               for (int n = 0; n < 16; n++) if (tbl[n] == sg) ok = 0;
            end
         end
         if (int'({an, sg}) == prev_in) an = ~(4'b0001 << ((d + 1) % 4));
         dwell(an, sg, len);
      end

      chk("locked_timing", 32'(lock_err), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
